// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one external memory port between two requesters: port 0 is the
//   multicycle CPU core, port 1 an auxiliary master (boot loader / debug DMA).
//   Round-robin arbitration, registered memory strobes, a variable-latency
//   memory handshake (mem_ready), and a one-cycle acknowledge per requester.
//
// Optional feature macro: MEMARB_STATS_EN
//   When defined, adds saturating per-port grant counters m0_count/m1_count
//   (STATW bits each), incremented once per completed access.
//
// Parameters
//   WIDTH   data and address width
//   STATW   width of each statistics counter (MEMARB_STATS_EN only)
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   mX_req/we/adr/wdata      requester X access request and its attributes
//   mX_ack                   requester X completion pulse (one cycle)
//   mX_rdata                 requester X read data, valid from mX_ack, held
//   mem_read/mem_write       registered memory strobes (never both high)
//   mem_adr/mem_wdata        registered memory address / write data
//   mem_rdata/mem_ready      memory read data / access-complete handshake
//   grant                    one-hot current owner, 2'b00 when idle
//   m0_count/m1_count        grant statistics (MEMARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH = 8
`ifdef MEMARB_STATS_EN
    ,
    parameter int STATW = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_adr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_ack,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_adr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_ack,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [1:0]       grant
`ifdef MEMARB_STATS_EN
    ,
    output logic [STATW-1:0] m0_count,
    output logic [STATW-1:0] m1_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             last_grant_r;     // 1: port 1 owned the memory last

    logic             elig0_s;
    logic             elig1_s;
    logic             start_s;
    logic             pick1_s;

    logic             sel_we_s;
    logic [WIDTH-1:0] sel_adr_s;
    logic [WIDTH-1:0] sel_wdata_s;

    logic             mem_read_nxt_s;
    logic             mem_write_nxt_s;
    logic [WIDTH-1:0] mem_adr_nxt_s;
    logic [WIDTH-1:0] mem_wdata_nxt_s;
    logic [1:0]       grant_nxt_s;
    logic             last_grant_nxt_s;
    logic             m0_ack_nxt_s;
    logic             m1_ack_nxt_s;
    logic [WIDTH-1:0] m0_rdata_nxt_s;
    logic [WIDTH-1:0] m1_rdata_nxt_s;

    // Arbitration decision: a port acked this cycle still shows its old req,
    // so it is masked out; on contention the port that did not go last wins.
    always_comb begin
        elig0_s     = m0_req & ~m0_ack;
        elig1_s     = m1_req & ~m1_ack;
        start_s     = elig0_s | elig1_s;
        pick1_s     = (elig0_s & elig1_s) ? ~last_grant_r : elig1_s;
        sel_we_s    = pick1_s ? m1_we    : m0_we;
        sel_adr_s   = pick1_s ? m1_adr   : m0_adr;
        sel_wdata_s = pick1_s ? m1_wdata : m0_wdata;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    next_state_s = pick1_s ? BUSY1 : BUSY0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY0: begin
                if (mem_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BUSY0;
                end
            end
            BUSY1: begin
                if (mem_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BUSY1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output.
    always_comb begin
        mem_read_nxt_s   = mem_read;
        mem_write_nxt_s  = mem_write;
        mem_adr_nxt_s    = mem_adr;
        mem_wdata_nxt_s  = mem_wdata;
        grant_nxt_s      = grant;
        last_grant_nxt_s = last_grant_r;
        m0_ack_nxt_s     = 1'b0;
        m1_ack_nxt_s     = 1'b0;
        m0_rdata_nxt_s   = m0_rdata;
        m1_rdata_nxt_s   = m1_rdata;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    // Strobes derive from a single we bit, so only one is high.
                    mem_read_nxt_s   = ~sel_we_s;
                    mem_write_nxt_s  = sel_we_s;
                    mem_adr_nxt_s    = sel_adr_s;
                    mem_wdata_nxt_s  = sel_wdata_s;
                    grant_nxt_s      = pick1_s ? 2'b10 : 2'b01;
                    last_grant_nxt_s = pick1_s;
                end else begin
                    // mem_ready while idle has no effect.
                    mem_read_nxt_s   = 1'b0;
                    mem_write_nxt_s  = 1'b0;
                    grant_nxt_s      = 2'b00;
                end
            end
            BUSY0: begin
                if (mem_ready) begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    grant_nxt_s     = 2'b00;
                    m0_ack_nxt_s    = 1'b1;
                    if (mem_read) begin
                        m0_rdata_nxt_s = mem_rdata;
                    end else begin
                        m0_rdata_nxt_s = m0_rdata;
                    end
                end else begin
                    grant_nxt_s = 2'b01;
                end
            end
            BUSY1: begin
                if (mem_ready) begin
                    mem_read_nxt_s  = 1'b0;
                    mem_write_nxt_s = 1'b0;
                    grant_nxt_s     = 2'b00;
                    m1_ack_nxt_s    = 1'b1;
                    if (mem_read) begin
                        m1_rdata_nxt_s = mem_rdata;
                    end else begin
                        m1_rdata_nxt_s = m1_rdata;
                    end
                end else begin
                    grant_nxt_s = 2'b10;
                end
            end
            default: begin
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
                grant_nxt_s     = 2'b00;
            end
        endcase
    end

    // Output and arbitration-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_adr      <= {WIDTH{1'b0}};
            mem_wdata    <= {WIDTH{1'b0}};
            grant        <= 2'b00;
            last_grant_r <= 1'b1;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= {WIDTH{1'b0}};
            m1_rdata     <= {WIDTH{1'b0}};
        end else begin
            mem_read     <= mem_read_nxt_s;
            mem_write    <= mem_write_nxt_s;
            mem_adr      <= mem_adr_nxt_s;
            mem_wdata    <= mem_wdata_nxt_s;
            grant        <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            m0_ack       <= m0_ack_nxt_s;
            m1_ack       <= m1_ack_nxt_s;
            m0_rdata     <= m0_rdata_nxt_s;
            m1_rdata     <= m1_rdata_nxt_s;
        end
    end

`ifdef MEMARB_STATS_EN
    // Saturating per-port completion counters, stepped by each ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_count <= {STATW{1'b0}};
            m1_count <= {STATW{1'b0}};
        end else begin
            if (m0_ack && (m0_count != {STATW{1'b1}})) begin
                m0_count <= m0_count + 1'b1;
            end else begin
                m0_count <= m0_count;
            end
            if (m1_ack && (m1_count != {STATW{1'b1}})) begin
                m1_count <= m1_count + 1'b1;
            end else begin
                m1_count <= m1_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed-vector bench for mem_arbiter. Inputs are driven and outputs are
//   sampled 1 time unit after the rising clock edge. Expected values are
//   hand-derived from the arbiter's cycle behaviour.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic       mem_read, mem_write, mem_ready;
    logic [7:0] mem_adr, mem_wdata, mem_rdata;
    logic [1:0] grant;
`ifdef MEMARB_STATS_EN
    logic [1:0] m0_count, m1_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_g  [0:7];
    logic       exp_a0 [0:7];
    logic       exp_a1 [0:7];

    always #5 clk = ~clk;

`ifdef MEMARB_STATS_EN
    mem_arbiter #(.WIDTH(8), .STATW(2)) dut (
`else
    mem_arbiter #(.WIDTH(8)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_adr    (m0_adr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_adr    (m1_adr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .grant     (grant)
`ifdef MEMARB_STATS_EN
        ,
        .m0_count  (m0_count),
        .m1_count  (m1_count)
`endif
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; m0_req = 1'b0; m0_we = 1'b0; m0_adr = 8'h00; m0_wdata = 8'h00;
        m1_req = 1'b0; m1_we = 1'b0; m1_adr = 8'h00; m1_wdata = 8'h00;
        mem_ready = 1'b0; mem_rdata = 8'h00;
        tick; tick;
        // Reset state
        check_val("rst_grant", {14'd0, grant}, 16'h0000);
        check_val("rst_rd", {15'd0, mem_read}, 16'h0000);
        check_val("rst_wr", {15'd0, mem_write}, 16'h0000);
        check_val("rst_adr", {8'd0, mem_adr}, 16'h0000);
        check_val("rst_ack", {14'd0, m0_ack, m1_ack}, 16'h0000);
        check_val("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
        rst = 1'b0;

        // 1: port 0 read, one-cycle memory
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 8'h10;
        tick;
        check_val("t1_grant", {14'd0, grant}, 16'h0001);
        check_val("t1_rd", {14'd0, mem_read, mem_write}, 16'h0002);
        check_val("t1_adr", {8'd0, mem_adr}, 16'h0010);
        check_val("t1_noack", {15'd0, m0_ack}, 16'h0000);
        mem_ready = 1'b1; mem_rdata = 8'hA5;
        tick;
        check_val("t1_ack", {15'd0, m0_ack}, 16'h0001);
        check_val("t1_rdata", {8'd0, m0_rdata}, 16'h00A5);
        check_val("t1_gnt0", {14'd0, grant}, 16'h0000);
        check_val("t1_rd0", {15'd0, mem_read}, 16'h0000);
        mem_ready = 1'b0; mem_rdata = 8'h00;
        // req still high during the ack cycle: must not be re-granted
        tick;
        check_val("t1_stale_ack", {15'd0, m0_ack}, 16'h0000);
        check_val("t1_stale_gnt", {14'd0, grant}, 16'h0000);
        check_val("t1_stale_rd", {15'd0, mem_read}, 16'h0000);
        check_val("t1_hold", {8'd0, m0_rdata}, 16'h00A5);
        m0_req = 1'b0;

        // 2: port 1 write, three wait cycles; input changes ignored
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 8'h20; m1_wdata = 8'h3C;
        tick;
        check_val("t2_grant", {14'd0, grant}, 16'h0002);
        check_val("t2_wr", {14'd0, mem_read, mem_write}, 16'h0001);
        check_val("t2_adr", {mem_adr, mem_wdata}, 16'h203C);
        m1_adr = 8'h55; m1_wdata = 8'h99; mem_rdata = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_val("t2_stable", {6'd0, grant, mem_adr}, 16'h0220);
            check_val("t2_stable_wd", {7'd0, mem_write, mem_wdata}, 16'h013C);
            check_val("t2_noack", {15'd0, m1_ack}, 16'h0000);
            if (k == 2) begin
                mem_ready = 1'b1;
            end
        end
        tick;
        check_val("t2_ack", {15'd0, m1_ack}, 16'h0001);
        check_val("t2_rdata_kept", {8'd0, m1_rdata}, 16'h0000);
        check_val("t2_wr0", {13'd0, mem_write, grant}, 16'h0000);
        mem_ready = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        tick;
        check_val("t2_ack_once", {15'd0, m1_ack}, 16'h0000);

        // 3: continuous contention from reset
        exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00;
        exp_g[4] = 2'b01; exp_g[5] = 2'b00; exp_g[6] = 2'b10; exp_g[7] = 2'b00;
        exp_a0[0] = 1'b0; exp_a0[1] = 1'b1; exp_a0[2] = 1'b0; exp_a0[3] = 1'b0;
        exp_a0[4] = 1'b0; exp_a0[5] = 1'b1; exp_a0[6] = 1'b0; exp_a0[7] = 1'b0;
        exp_a1[0] = 1'b0; exp_a1[1] = 1'b0; exp_a1[2] = 1'b0; exp_a1[3] = 1'b1;
        exp_a1[4] = 1'b0; exp_a1[5] = 1'b0; exp_a1[6] = 1'b0; exp_a1[7] = 1'b1;
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_adr = 8'h01; m1_adr = 8'h02;
        mem_ready = 1'b1; mem_rdata = 8'h77;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            check_val("t3_grant", {14'd0, grant}, {14'd0, exp_g[i]});
            check_val("t3_acks", {14'd0, m0_ack, m1_ack}, {14'd0, exp_a0[i], exp_a1[i]});
        end
        check_val("t3_rdata", {m0_rdata, m1_rdata}, 16'h7777);
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
        tick;
        check_val("t3_idle", {14'd0, grant}, 16'h0000);

        // 4: reset during BUSY1
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 8'h40;
        tick;
        check_val("t4_grant1", {14'd0, grant}, 16'h0002);
        tick;
        check_val("t4_busy", {7'd0, mem_read, mem_adr}, 16'h0140);
        rst = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_adr = 8'h50;
        tick;
        check_val("t4_rst_out", {13'd0, grant, mem_read}, 16'h0000);
        check_val("t4_rst_adr", {8'd0, mem_adr}, 16'h0000);
        check_val("t4_rst_ack", {14'd0, m0_ack, m1_ack}, 16'h0000);
        check_val("t4_rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
        rst = 1'b0;
        tick;
        check_val("t4_p0_wins", {14'd0, grant}, 16'h0001);
        check_val("t4_no_ack1", {15'd0, m1_ack}, 16'h0000);
        check_val("t4_adr", {8'd0, mem_adr}, 16'h0050);
        mem_ready = 1'b1; mem_rdata = 8'h5A;
        tick;
        check_val("t4_ack0", {14'd0, m0_ack, m1_ack}, 16'h0002);
        check_val("t4_rdata", {8'd0, m0_rdata}, 16'h005A);
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
        tick;

        // 5: mem_ready while idle; req dropped mid-access
        mem_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick;
            check_val("t5_idle", {11'd0, mem_read, mem_write, grant, m0_ack}, 16'h0000);
            check_val("t5_idle_ack1", {15'd0, m1_ack}, 16'h0000);
        end
        mem_ready = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_adr = 8'h33; m0_wdata = 8'h44;
        tick;
        check_val("t5_wr", {12'd0, mem_read, mem_write, grant}, 16'h0005);
        m0_req = 1'b0;
        tick;
        check_val("t5_wr_held", {7'd0, mem_write, mem_wdata}, 16'h0144);
        check_val("t5_noack", {15'd0, m0_ack}, 16'h0000);
        mem_ready = 1'b1; mem_rdata = 8'hC3;
        tick;
        check_val("t5_ack", {14'd0, m0_ack, mem_write}, 16'h0002);
        check_val("t5_rdata_kept", {8'd0, m0_rdata}, 16'h005A);
        mem_ready = 1'b0;
        tick;
        check_val("t5_ack_once", {13'd0, m0_ack, grant}, 16'h0000);

`ifdef MEMARB_STATS_EN
        // 6: saturating statistics counter, STATW = 2
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("t6_rst_cnt", {12'd0, m0_count, m1_count}, 16'h0000);
        m0_req = 1'b1; m0_we = 1'b0; mem_ready = 1'b1;
        repeat (15) tick;
        m0_req = 1'b0; mem_ready = 1'b0;
        tick; tick;
        check_val("t6_m0_count", {14'd0, m0_count}, 16'h0003);
        check_val("t6_m1_count", {14'd0, m1_count}, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
